// File: rtl/vga_linear_fml_fetch_pkg.sv
// Shared geometry, timing constants and address helper for the linear 256-colour fetch path.
package vga_linear_fml_fetch_pkg;
    localparam int BURST_WORDS = 8;
    localparam int ROW_WORDS   = 160;
    localparam int PIPE_DEPTH  = 5;
    localparam int FML_LATENCY = 3;
    localparam int PREFETCH_H  = 768;
    localparam int H_VISIBLE   = 640;

    // FML word address, bit 0 here corresponds to byte-address bit 1
    typedef logic [16:0] word_adr_t;

    localparam logic [3:0] BEAT_LAST = 4'(FML_LATENCY + BURST_WORDS - 1);

    function automatic word_adr_t burst_base(input logic [7:0] row, input logic [4:0] grp);
        return word_adr_t'(row) * word_adr_t'(ROW_WORDS) + (word_adr_t'(grp) << 3);
    endfunction
endpackage

// File: rtl/vga_linear_fml_fetch_if.sv
// CRTC timing, FML read bus and pixel output bundle for the linear fetch block.
interface vga_linear_fml_fetch_if;
    import vga_linear_fml_fetch_pkg::*;

    logic        enable;
    word_adr_t   fml_adr_o;
    logic        fml_stb_o;
    logic [15:0] fml_dat_i;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        horiz_sync_i;
    logic        video_on_h_i;
    logic        video_on_h_o;
    logic        horiz_sync_o;
    logic [7:0]  color;

    modport master (
        input  enable, fml_dat_i, h_count, v_count, horiz_sync_i, video_on_h_i,
        output fml_adr_o, fml_stb_o, video_on_h_o, horiz_sync_o, color
    );

    modport slave (
        output enable, fml_dat_i, h_count, v_count, horiz_sync_i, video_on_h_i,
        input  fml_adr_o, fml_stb_o, video_on_h_o, horiz_sync_o, color
    );
endinterface

// File: rtl/vga_linear_fml_fetch_burst_buffer.sv
// 2x8x16 double buffer: captures one fixed-latency burst into the back half, swaps on group match.
// Read mux is combinational from the front half; no ack, beats are taken blindly by count.
module vga_fml_burst_buffer
    import vga_linear_fml_fetch_pkg::*;
(
    input  logic        clk_50,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  start_grp,
    input  logic [15:0] fml_dat,
    input  logic        swap_chk,
    input  logic [4:0]  cur_grp,
    input  logic [3:0]  rd_byte,
    output logic        busy,
    output logic [7:0]  rd_dat
);
    logic [1:0][7:0][15:0] mem_q, mem_d;
    logic [3:0]            beat_q, beat_d;
    logic                  sel_q, sel_d;
    logic                  full_q, full_d;
    logic [4:0]            fill_grp_q, fill_grp_d;
    logic [2:0]            widx;
    logic [15:0]           rd_word;

    assign widx    = 3'(beat_q - 4'(FML_LATENCY));
    assign busy    = start || (beat_q != 4'd0);
    assign rd_word = mem_q[sel_q][rd_byte[3:1]];
    assign rd_dat  = rd_byte[0] ? rd_word[15:8] : rd_word[7:0];

    always_comb begin
        mem_d      = mem_q;
        beat_d     = beat_q;
        sel_d      = sel_q;
        full_d     = full_q;
        fill_grp_d = fill_grp_q;

        if (swap_chk && full_q && (fill_grp_q == cur_grp)) begin
            sel_d  = ~sel_q;
            full_d = 1'b0;
        end

        // beat_q counts edges since the strobe was sampled; 0 means idle
        if (start && (beat_q == 4'd0)) begin
            beat_d = 4'd1;
            full_d = 1'b0;
        end else if (beat_q != 4'd0) begin
            beat_d = beat_q + 4'd1;
            if (beat_q >= 4'(FML_LATENCY)) begin
                mem_d[~sel_q][widx] = fml_dat;
            end
            if (beat_q == BEAT_LAST) begin
                beat_d     = 4'd0;
                full_d     = 1'b1;
                fill_grp_d = start_grp;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            mem_q      <= '0;
            beat_q     <= 4'd0;
            sel_q      <= 1'b0;
            full_q     <= 1'b0;
            fill_grp_q <= 5'd0;
        end else begin
            mem_q      <= mem_d;
            beat_q     <= beat_d;
            sel_q      <= sel_d;
            full_q     <= full_d;
            fill_grp_q <= fill_grp_d;
        end
    end
endmodule

// File: rtl/vga_linear_fml_fetch.sv
// Linear 256-colour pixel fetch: bursts the next 32-column group from FML, emits one colour per clock.
// Colour and sync outputs trail h/v/sync inputs by PIPE_DEPTH clocks; triggers during a burst are dropped.
module vga_linear_fml_fetch
    import vga_linear_fml_fetch_pkg::*;
(
    input  logic                   clk_50,
    input  logic                   rst,
    vga_linear_fml_fetch_if.master bus
);
    logic                  stb_q, stb_d;
    word_adr_t             adr_q, adr_d;
    logic [4:0]            grp_q, grp_d;
    logic [PIPE_DEPTH-1:0] vid_q, vid_d;
    logic [PIPE_DEPTH-1:0] hs_q, hs_d;
    logic [3:0]            pix_q, pix_d;
    logic                  en1_q, en1_d;
    logic [3:0][7:0]       col_q, col_d;

    logic       at_grp;
    logic [9:0] v_next;
    logic       busy;
    logic [7:0] rd_dat;
    logic       unused_bits;

    assign at_grp      = (bus.h_count[4:0] == 5'd0);
    assign v_next      = bus.v_count + 10'd1;
    assign unused_bits = ^{bus.v_count[9], bus.v_count[0], v_next[9], v_next[0]};

    always_comb begin
        stb_d = 1'b0;
        adr_d = adr_q;
        grp_d = grp_q;
        if (bus.enable && at_grp && !busy) begin
            if (bus.h_count < 10'(H_VISIBLE)) begin
                stb_d = 1'b1;
                grp_d = bus.h_count[9:5] + 5'd1;
                adr_d = burst_base(bus.v_count[8:1], grp_d);
            end else if (bus.h_count == 10'(PREFETCH_H)) begin
                stb_d = 1'b1;
                grp_d = 5'd0;
                adr_d = burst_base(v_next[8:1], 5'd0);
            end
        end

        vid_d = {vid_q[PIPE_DEPTH-2:0], bus.video_on_h_i};
        hs_d  = {hs_q[PIPE_DEPTH-2:0], bus.horiz_sync_i};
        pix_d = bus.h_count[4:1];
        en1_d = bus.enable;
        // stage 2 reads the buffer one clock after a swap so the new group's first pixel sees it
        col_d = {col_q[2:0], (en1_q ? rd_dat : 8'd0)};
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            stb_q <= 1'b0;
            adr_q <= '0;
            grp_q <= 5'd0;
            vid_q <= '0;
            hs_q  <= '0;
            pix_q <= 4'd0;
            en1_q <= 1'b0;
            col_q <= '0;
        end else begin
            stb_q <= stb_d;
            adr_q <= adr_d;
            grp_q <= grp_d;
            vid_q <= vid_d;
            hs_q  <= hs_d;
            pix_q <= pix_d;
            en1_q <= en1_d;
            col_q <= col_d;
        end
    end

    vga_fml_burst_buffer u_buf (
        .clk_50    (clk_50),
        .rst       (rst),
        .start     (stb_q),
        .start_grp (grp_q),
        .fml_dat   (bus.fml_dat_i),
        .swap_chk  (at_grp),
        .cur_grp   (bus.h_count[9:5]),
        .rd_byte   (pix_q),
        .busy      (busy),
        .rd_dat    (rd_dat)
    );

    assign bus.fml_stb_o    = stb_q;
    assign bus.fml_adr_o    = adr_q;
    assign bus.video_on_h_o = vid_q[PIPE_DEPTH-1];
    assign bus.horiz_sync_o = hs_q[PIPE_DEPTH-1];
    assign bus.color        = col_q[3];
endmodule

// File: tb/tb_vga_linear_fml_fetch.sv
// Bench for the linear fetch block: address vector table, busy-drop sequence and a scoreboarded CRTC run.
module tb_vga_linear_fml_fetch;
    import vga_linear_fml_fetch_pkg::*;

    logic clk_50 = 1'b0;
    logic rst;

    vga_linear_fml_fetch_if bus ();

    vga_linear_fml_fetch dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus.master)
    );

    always #10 clk_50 = ~clk_50;

    // Frame-buffer contents; base 176 yields BEEF, F5D7, F5D6, ...
    function automatic logic [15:0] mem_word(input word_adr_t a);
        logic [15:0] base;
        logic [16:0] mix;
        base = (a[2:0] == 3'd0) ? 16'hBEEF : (16'hF5D8 - {13'd0, a[2:0]});
        mix  = ((a >> 3) - 17'd22) * 17'h2B7;
        return base ^ mix[15:0];
    endfunction

    logic [3:0] mcnt  = 4'd0;
    word_adr_t  mbase = '0;

    always @(posedge clk_50) begin
        if (bus.fml_stb_o) begin
            mcnt  <= 4'd1;
            mbase <= bus.fml_adr_o;
        end else if (mcnt == 4'd10) begin
            mcnt <= 4'd0;
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt + 4'd1;
        end
    end

    assign bus.fml_dat_i = (mcnt >= 4'd3 && mcnt <= 4'd10) ?
                           mem_word(mbase + 17'(mcnt - 4'd3)) : 16'hDEAD;

    typedef struct packed {
        logic       care;
        logic [7:0] color;
        logic       hs;
        logic       vo;
    } exp_t;

    exp_t sbq[$];

    bit         fv;
    word_adr_t  fbase;
    bit         pv;
    logic [4:0] pgrp;
    word_adr_t  pbase;
    word_adr_t  madr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs, update the spec model, then compare outputs just after the edge.
    task automatic cycle(input bit r, input bit en, input logic [9:0] h, input logic [9:0] v,
                         input bit chk_c, input bit chk_f);
        exp_t        e;
        logic        hs;
        logic        vo;
        logic [15:0] w;
        bit          e_stb;
        logic [9:0]  vn;
        hs = 1'($urandom);
        vo = 1'($urandom);
        rst              = r;
        bus.enable       = en;
        bus.h_count      = h;
        bus.v_count      = v;
        bus.horiz_sync_i = hs;
        bus.video_on_h_i = vo;
        e_stb = 1'b0;
        if (r) begin
            fv   = 1'b0;
            pv   = 1'b0;
            madr = '0;
            sbq.delete();
            e.care = 1'b1; e.color = 8'd0; e.hs = 1'b0; e.vo = 1'b0;
            repeat (5) sbq.push_back(e);
        end else begin
            if (h[4:0] == 5'd0 && pv && pgrp == h[9:5]) begin
                fv    = 1'b1;
                fbase = pbase;
                pv    = 1'b0;
            end
            w = fv ? mem_word(fbase + 17'(h[4:2])) : 16'd0;
            e.care  = chk_c;
            e.color = en ? (h[1] ? w[15:8] : w[7:0]) : 8'd0;
            e.hs    = hs;
            e.vo    = vo;
            sbq.push_back(e);
            if (en && h[4:0] == 5'd0) begin
                vn = v + 10'd1;
                if (h < 10'd640) begin
                    e_stb = 1'b1;
                    pgrp  = h[9:5] + 5'd1;
                    pbase = 17'(v[8:1]) * 17'd160 + 17'(pgrp) * 17'd8;
                    pv    = 1'b1;
                    madr  = pbase;
                end else if (h == 10'd768) begin
                    e_stb = 1'b1;
                    pgrp  = 5'd0;
                    pbase = 17'(vn[8:1]) * 17'd160;
                    pv    = 1'b1;
                    madr  = pbase;
                end
            end
        end
        @(posedge clk_50);
        #1;
        e = sbq.pop_front();
        if (e.care) check("color", 32'(bus.color), 32'(e.color));
        check("horiz_sync_o", 32'(bus.horiz_sync_o), 32'(e.hs));
        check("video_on_h_o", 32'(bus.video_on_h_o), 32'(e.vo));
        if (chk_f) begin
            check("fml_stb_o", 32'(bus.fml_stb_o), 32'(e_stb));
            check("fml_adr_o", 32'(bus.fml_adr_o), 32'(madr));
        end
    endtask

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       en;
        logic       stb;
        word_adr_t  adr;
    } vec_t;

    vec_t vt[12];
    logic [7:0] spec_col[6];

    initial begin
        logic [9:0] h;
        logic [9:0] v;
        bit         r;
        bit         en;

        vt[0]  = '{h: 10'd32,  v: 10'd2,   en: 1'b1, stb: 1'b1, adr: 17'd176};
        vt[1]  = '{h: 10'd768, v: 10'd1,   en: 1'b1, stb: 1'b1, adr: 17'd160};
        vt[2]  = '{h: 10'd0,   v: 10'd0,   en: 1'b1, stb: 1'b1, adr: 17'd8};
        vt[3]  = '{h: 10'd64,  v: 10'd5,   en: 1'b1, stb: 1'b1, adr: 17'd344};
        vt[4]  = '{h: 10'd608, v: 10'd10,  en: 1'b1, stb: 1'b1, adr: 17'd960};
        vt[5]  = '{h: 10'd640, v: 10'd10,  en: 1'b1, stb: 1'b0, adr: 17'd960};
        vt[6]  = '{h: 10'd33,  v: 10'd10,  en: 1'b1, stb: 1'b0, adr: 17'd960};
        vt[7]  = '{h: 10'd96,  v: 10'd10,  en: 1'b0, stb: 1'b0, adr: 17'd960};
        vt[8]  = '{h: 10'd768, v: 10'd399, en: 1'b1, stb: 1'b1, adr: 17'd32000};
        vt[9]  = '{h: 10'd768, v: 10'd511, en: 1'b1, stb: 1'b1, adr: 17'd0};
        vt[10] = '{h: 10'd736, v: 10'd0,   en: 1'b1, stb: 1'b0, adr: 17'd0};
        vt[11] = '{h: 10'd0,   v: 10'd399, en: 1'b1, stb: 1'b1, adr: 17'd31848};
        spec_col = '{8'hEF, 8'hEF, 8'hBE, 8'hBE, 8'hD7, 8'hD7};

        cycle(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, vt[i].en, vt[i].h, vt[i].v, 1'b0, 1'b0);
            check($sformatf("vec%0d_stb", i), 32'(bus.fml_stb_o), 32'(vt[i].stb));
            check($sformatf("vec%0d_adr", i), 32'(bus.fml_adr_o), 32'(vt[i].adr));
            cycle(1'b0, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0);
            check($sformatf("vec%0d_stb_one_cycle", i), 32'(bus.fml_stb_o), 32'd0);
            check($sformatf("vec%0d_adr_hold", i), 32'(bus.fml_adr_o), 32'(vt[i].adr));
            repeat (11) cycle(1'b0, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0);
        end

        // A second trigger four clocks into a burst must be dropped.
        cycle(1'b0, 1'b1, 10'd32, 10'd0, 1'b0, 1'b0);
        check("drop_first_stb", 32'(bus.fml_stb_o), 32'd1);
        check("drop_first_adr", 32'(bus.fml_adr_o), 32'd16);
        repeat (3) cycle(1'b0, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 10'd64, 10'd0, 1'b0, 1'b0);
        check("drop_busy_stb", 32'(bus.fml_stb_o), 32'd0);
        check("drop_busy_adr", 32'(bus.fml_adr_o), 32'd16);
        repeat (12) cycle(1'b0, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 10'd64, 10'd0, 1'b0, 1'b0);
        check("drop_retry_stb", 32'(bus.fml_stb_o), 32'd1);
        check("drop_retry_adr", 32'(bus.fml_adr_o), 32'd24);

        // Continuous raster: enable dropout on line 3, reset mid-burst on line 4.
        cycle(1'b1, 1'b1, 10'd789, 10'd524, 1'b1, 1'b1);
        h = 10'd790;
        v = 10'd524;
        while (!(v == 10'd7 && h == 10'd0)) begin
            r  = (v == 10'd4 && h == 10'd40);
            en = !(v == 10'd3 && h >= 10'd20 && h <= 10'd50);
            cycle(r, en, h, v, 1'b1, 1'b1);
            if (v == 10'd2 && h >= 10'd68 && h <= 10'd73)
                check("spec_color", 32'(bus.color), 32'(spec_col[int'(h) - 68]));
            if (h == 10'd799) begin
                h = 10'd0;
                v = (v == 10'd524) ? 10'd0 : v + 10'd1;
            end else begin
                h = h + 10'd1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
